// File: rtl/axi4lite_master_bridge_pkg.sv
// Shared AXI4-Lite response codes, bridge FSM encodings and a state-class helper.
package axi4lite_master_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD      = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  // States in which the bus transaction is still open and wait cycles accrue.
  function automatic logic in_xfer(input logic [2:0] st);
    return (st == ST_WR) || (st == ST_WR_RESP) || (st == ST_RD) || (st == ST_RD_WAIT);
  endfunction

endpackage

// File: rtl/axi4lite_master_bridge_if.sv
// Command/response handshake plus AXI4-Lite master channels; master = bridge side, slave = environment.
interface axi4lite_master_bridge_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_resp;

  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    output m_axi_araddr, m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid, m_axi_rready
  );

endinterface

// File: rtl/axi4lite_master_bridge_timeout_ctr.sv
// Wait-cycle counter: clears whenever i_run is low; o_expired fires on the TIMEOUT_CYCLES-th running cycle.
module axi4lite_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_expired
);
  localparam int              CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_run && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || o_expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/axi4lite_master_bridge.sv
// One-at-a-time command -> AXI4-Lite write/read -> response bridge; >=3 cycles cmd to rsp, rsp held until rsp_ready.
// Define AXI_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES with SLVERR.
module axi4lite_master_bridge
  import axi4lite_master_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  axi4lite_master_bridge_if.master bus
);

  logic [2:0]            r_state;
  logic                  r_cmd_ready;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_aw_done, w_w_done, w_ar_done;
  logic w_run, w_timeout;

  assign w_aw_hs   = r_awvalid && bus.m_axi_awready;
  assign w_w_hs    = r_wvalid  && bus.m_axi_wready;
  assign w_b_hs    = r_bready  && bus.m_axi_bvalid;
  assign w_ar_hs   = r_arvalid && bus.m_axi_arready;
  assign w_r_hs    = r_rready  && bus.m_axi_rvalid;
  assign w_aw_done = !r_awvalid || bus.m_axi_awready;
  assign w_w_done  = !r_wvalid  || bus.m_axi_wready;
  assign w_ar_done = !r_arvalid || bus.m_axi_arready;
  assign w_run     = in_xfer(r_state);

`ifdef AXI_TIMEOUT_EN
  axi4lite_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk       (s_axi_aclk),
    .rst_n     (s_axi_aresetn),
    .i_run     (w_run),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_resp      <= RESP_OKAY;
    end else if (w_timeout) begin
      // Abandon the stalled transaction outright and report it as a slave error.
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rdata     <= '0;
      r_resp      <= RESP_SLVERR;
      r_rsp_valid <= 1'b1;
      r_state     <= ST_RSP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_cmd_ready && bus.cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= bus.cmd_addr;
            r_wdata     <= bus.cmd_write ? bus.cmd_wdata : '0;
            r_rdata     <= '0;
            r_resp      <= RESP_OKAY;
            if (bus.cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_bready  <= 1'b1;
              r_state   <= ST_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
              r_state   <= ST_RD;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        ST_WR: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_b_hs) begin
            r_bready <= 1'b0;
            r_resp   <= bus.m_axi_bresp;
          end
          // bready already low means B was taken on an earlier WR cycle.
          if (w_aw_done && w_w_done) begin
            if (w_b_hs || !r_bready) begin
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RSP;
            end else begin
              r_state     <= ST_WR_RESP;
            end
          end
        end

        ST_WR_RESP: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_resp      <= bus.m_axi_bresp;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end

        ST_RD: begin
          if (w_ar_hs) r_arvalid <= 1'b0;
          if (w_r_hs) begin
            r_rready <= 1'b0;
            r_rdata  <= bus.m_axi_rdata;
            r_resp   <= bus.m_axi_rresp;
          end
          if (w_ar_done) begin
            if (w_r_hs || !r_rready) begin
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RSP;
            end else begin
              r_state     <= ST_RD_WAIT;
            end
          end
        end

        ST_RD_WAIT: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rdata     <= bus.m_axi_rdata;
            r_resp      <= bus.m_axi_rresp;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_cmd_ready <= 1'b0;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = r_cmd_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_rdata     = r_rdata;
  assign bus.rsp_resp      = r_resp;
  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wvalid  = r_wvalid;
  assign bus.m_axi_bready  = r_bready;
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_rready;

endmodule
